// File: rtl/stage_mem_access.sv
// stage_mem_access: MIPS MEM stage with req/ack data-memory access and MEM/WB latch; DMEM_TIMEOUT_EN adds an ack timeout
module stage_mem_access #(
    parameter int BITS_SIZE      = 32,
    parameter int BITS_REGS      = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
`ifdef DMEM_TIMEOUT_EN
    output logic                 o_dmem_error,
`endif
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_exmem_valid,
    input  logic [BITS_SIZE-1:0] i_exmem_alu,
    input  logic [BITS_SIZE-1:0] i_exmem_data_store,
    input  logic                 i_exmem_mem_read,
    input  logic                 i_exmem_mem_write,
    input  logic [1:0]           i_exmem_size_filterL,
    input  logic [1:0]           i_exmem_size_filterS,
    input  logic                 i_exmem_zero_extend,
    input  logic                 i_exmem_lui,
    input  logic [BITS_SIZE-1:0] i_exmem_extension,
    input  logic                 i_exmem_mem_to_reg,
    input  logic                 i_exmem_reg_write,
    input  logic [BITS_REGS-1:0] i_exmem_rd,
    output logic                 o_dmem_req,
    output logic                 o_dmem_we,
    output logic [BITS_SIZE-1:0] o_dmem_addr,
    output logic [BITS_SIZE-1:0] o_dmem_wdata,
    output logic [3:0]           o_dmem_be,
    input  logic                 i_dmem_ack,
    input  logic [BITS_SIZE-1:0] i_dmem_rdata,
    output logic                 o_mem_stall,
    output logic                 o_misaligned,
    output logic [BITS_SIZE-1:0] o_memwb_alu,
    output logic [BITS_SIZE-1:0] o_memwb_extension,
    output logic [BITS_SIZE-1:0] o_memwb_dato_mem,
    output logic [1:0]           o_memwb_size_filterL,
    output logic                 o_memwb_zero_extend,
    output logic                 o_memwb_lui,
    output logic                 o_memwb_mem_to_reg,
    output logic                 o_memwb_reg_write,
    output logic [BITS_REGS-1:0] o_memwb_rd
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state, state_nx;
    logic [1:0]             size;
    logic                   mem_op, bad, go, tmo, done, wb_en, wb_take, wb_rw;
    logic [BITS_SIZE-1:0]   st_wdata, sh_b, sh_h, ld_data, wb_dato;
    logic [3:0]             st_be;

`ifdef DMEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign tmo = state == S_WAIT && cnt == CW'(TIMEOUT_CYCLES - 1) && !i_dmem_ack;
`else
    assign tmo = 1'b0;
`endif

    always_comb begin
        size     = i_exmem_mem_write ? i_exmem_size_filterS : i_exmem_size_filterL;
        mem_op   = i_exmem_valid & (i_exmem_mem_read | i_exmem_mem_write);
        bad      = (size == 2'b11) | (size == 2'b10 & i_exmem_alu[0]) | (size == 2'b00 & |i_exmem_alu[1:0]);
        go       = mem_op & !bad;
        done     = state == S_WAIT && (i_dmem_ack || tmo);
        state_nx = state == S_IDLE ? (go ? S_WAIT : S_IDLE) : (done ? S_IDLE : S_WAIT);
        o_mem_stall = state == S_IDLE ? go : !(i_dmem_ack || tmo);
        st_wdata = i_exmem_size_filterS == 2'b01 ? {(BITS_SIZE/8){i_exmem_data_store[7:0]}} :
                   i_exmem_size_filterS == 2'b10 ? {(BITS_SIZE/16){i_exmem_data_store[15:0]}} :
                   i_exmem_data_store;
        st_be    = i_exmem_size_filterS == 2'b01 ? 4'b0001 << i_exmem_alu[1:0] :
                   i_exmem_size_filterS == 2'b10 ? (i_exmem_alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        sh_b     = i_dmem_rdata >> {i_exmem_alu[1:0], 3'b000};
        sh_h     = i_dmem_rdata >> {i_exmem_alu[1], 4'b0000};
        ld_data  = i_exmem_size_filterL == 2'b01 ? {{(BITS_SIZE-8){1'b0}}, sh_b[7:0]} :
                   i_exmem_size_filterL == 2'b10 ? {{(BITS_SIZE-16){1'b0}}, sh_h[15:0]} :
                   i_dmem_rdata;
        // MEM/WB loads either the instruction itself or a bubble
        wb_en    = state == S_IDLE || done;
        wb_take  = state == S_IDLE ? !mem_op : i_dmem_ack;
        wb_rw    = wb_take & i_exmem_valid & i_exmem_reg_write & !i_exmem_mem_write;
        wb_dato  = (state == S_WAIT && wb_take && !i_exmem_mem_write) ? ld_data : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state                <= S_IDLE;
            o_dmem_req           <= 1'b0;
            o_dmem_we            <= 1'b0;
            o_dmem_addr          <= '0;
            o_dmem_wdata         <= '0;
            o_dmem_be            <= '0;
            o_misaligned         <= 1'b0;
            o_memwb_alu          <= '0;
            o_memwb_extension    <= '0;
            o_memwb_dato_mem     <= '0;
            o_memwb_size_filterL <= '0;
            o_memwb_zero_extend  <= 1'b0;
            o_memwb_lui          <= 1'b0;
            o_memwb_mem_to_reg   <= 1'b0;
            o_memwb_reg_write    <= 1'b0;
            o_memwb_rd           <= '0;
        end else begin
            state        <= state_nx;
            o_misaligned <= state == S_IDLE && mem_op && bad;
            if (state == S_IDLE) begin
                o_dmem_req   <= go;
                o_dmem_we    <= go & i_exmem_mem_write;
                o_dmem_addr  <= go ? {i_exmem_alu[BITS_SIZE-1:2], 2'b00} : '0;
                o_dmem_wdata <= (go & i_exmem_mem_write) ? st_wdata : '0;
                o_dmem_be    <= (go & i_exmem_mem_write) ? st_be : '0;
            end else if (done) begin
                o_dmem_req   <= 1'b0;
                o_dmem_we    <= 1'b0;
                o_dmem_addr  <= '0;
                o_dmem_wdata <= '0;
                o_dmem_be    <= '0;
            end
            if (wb_en) begin
                o_memwb_alu          <= wb_take ? i_exmem_alu : '0;
                o_memwb_extension    <= wb_take ? i_exmem_extension : '0;
                o_memwb_dato_mem     <= wb_dato;
                o_memwb_size_filterL <= wb_take ? i_exmem_size_filterL : '0;
                o_memwb_zero_extend  <= wb_take & i_exmem_zero_extend;
                o_memwb_lui          <= wb_take & i_exmem_lui;
                o_memwb_mem_to_reg   <= wb_take & i_exmem_mem_to_reg;
                o_memwb_reg_write    <= wb_rw;
                o_memwb_rd           <= wb_take ? i_exmem_rd : '0;
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt          <= '0;
            o_dmem_error <= 1'b0;
        end else begin
            cnt          <= state == S_WAIT ? cnt + 1'b1 : '0;
            o_dmem_error <= o_dmem_error | tmo;
        end
    end
`endif

endmodule

// File: tb/tb_stage_mem_access.sv
// tb_stage_mem_access: directed vectors with hand-computed results for stage_mem_access
module tb_stage_mem_access;

    logic        i_clk, i_reset;
    logic        valid, mem_read, mem_write, zero_extend, lui, mem_to_reg, reg_write;
    logic [31:0] alu, data_store, extension, rdata;
    logic [1:0]  size_l, size_s;
    logic [4:0]  rd;
    logic        ack;
    logic        dmem_req, dmem_we, mem_stall, misaligned;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] wb_alu, wb_ext, wb_dato;
    logic [1:0]  wb_size;
    logic        wb_zext, wb_lui, wb_m2r, wb_rw;
    logic [4:0]  wb_rd;
`ifdef DMEM_TIMEOUT_EN
    logic        dmem_error;
`endif
    int n_cmp = 0;
    int n_err = 0;

    stage_mem_access dut (
`ifdef DMEM_TIMEOUT_EN
        .o_dmem_error(dmem_error),
`endif
        .i_clk(i_clk), .i_reset(i_reset),
        .i_exmem_valid(valid), .i_exmem_alu(alu), .i_exmem_data_store(data_store),
        .i_exmem_mem_read(mem_read), .i_exmem_mem_write(mem_write),
        .i_exmem_size_filterL(size_l), .i_exmem_size_filterS(size_s),
        .i_exmem_zero_extend(zero_extend), .i_exmem_lui(lui), .i_exmem_extension(extension),
        .i_exmem_mem_to_reg(mem_to_reg), .i_exmem_reg_write(reg_write), .i_exmem_rd(rd),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_ack(ack), .i_dmem_rdata(rdata),
        .o_mem_stall(mem_stall), .o_misaligned(misaligned),
        .o_memwb_alu(wb_alu), .o_memwb_extension(wb_ext), .o_memwb_dato_mem(wb_dato),
        .o_memwb_size_filterL(wb_size), .o_memwb_zero_extend(wb_zext), .o_memwb_lui(wb_lui),
        .o_memwb_mem_to_reg(wb_m2r), .o_memwb_reg_write(wb_rw), .o_memwb_rd(wb_rd)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        valid = 0; mem_read = 0; mem_write = 0; zero_extend = 0; lui = 0;
        mem_to_reg = 0; reg_write = 0; alu = 0; data_store = 0; extension = 0;
        size_l = 0; size_s = 0; rd = 0; ack = 0; rdata = 0;
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive_mem(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] sd);
        valid = 1; alu = a; data_store = sd; mem_read = !w; mem_write = w;
        size_l = w ? 2'b00 : sz; size_s = w ? sz : 2'b00;
        reg_write = 1; mem_to_reg = !w; rd = 5'd7;
    endtask

    // one access acknowledged on the first WAIT cycle
    task automatic mem_access(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] sd, input logic [31:0] rw, input logic [31:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_dato);
        drive_mem(w, sz, a, sd);
        #1 check({tag, "_stall_idle"}, mem_stall, 1);
        check({tag, "_noreq_idle"}, dmem_req, 0);
        tick();
        check({tag, "_req"}, dmem_req, 1);
        check({tag, "_we"}, dmem_we, w);
        check({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
        check({tag, "_be"}, dmem_be, exp_be);
        check({tag, "_wdata"}, dmem_wdata, exp_wd);
        check({tag, "_bubble"}, wb_rw, 0);
        ack = 1; rdata = rw;
        #1 check({tag, "_stall_ack"}, mem_stall, 0);
        tick();
        check({tag, "_req_drop"}, dmem_req, 0);
        check({tag, "_wb_rw"}, wb_rw, !w);
        check({tag, "_wb_dato"}, wb_dato, exp_dato);
        check({tag, "_wb_alu"}, wb_alu, a);
        check({tag, "_wb_size"}, wb_size, w ? 2'b00 : sz);
        idle_in();
    endtask

    task automatic misalign(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
        drive_mem(w, sz, a, 32'h55);
        #1 check({tag, "_stall"}, mem_stall, 0);
        tick();
        check({tag, "_noreq"}, dmem_req, 0);
        check({tag, "_pulse"}, misaligned, 1);
        check({tag, "_wb_rw"}, wb_rw, 0);
        idle_in();
        tick();
        check({tag, "_pulse_end"}, misaligned, 0);
        check({tag, "_noreq2"}, dmem_req, 0);
    endtask

    initial begin
        idle_in();
        i_reset = 1;
        #2;
        check("rst_req", dmem_req, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wb_rw", wb_rw, 0);
        check("rst_misal", misaligned, 0);
        tick();
        i_reset = 0;

        // ADD
        valid = 1; alu = 32'h2A; reg_write = 1; rd = 5'd3; extension = 32'h1234_0000;
        #1 check("add_stall", mem_stall, 0);
        tick();
        check("add_alu", wb_alu, 32'h2A);
        check("add_rd", wb_rd, 3);
        check("add_rw", wb_rw, 1);
        check("add_ext", wb_ext, 32'h1234_0000);
        check("add_stall2", mem_stall, 0);
        valid = 0;
        tick();
        check("invalid_rw", wb_rw, 0);
        idle_in();

        mem_access("lb103", 0, 2'b01, 32'h103, 0, 32'h8000_0000, 0, 0, 32'h80);
        mem_access("lb100", 0, 2'b01, 32'h100, 0, 32'h1122_3344, 0, 0, 32'h44);
        mem_access("lh102", 0, 2'b10, 32'h102, 0, 32'hABCD_1234, 0, 0, 32'hABCD);
        mem_access("sh202", 1, 2'b10, 32'h202, 32'h1234, 32'hFFFF_FFFF, 32'hC, 32'h1234_1234, 0);
        mem_access("sb301", 1, 2'b01, 32'h301, 32'hA5, 0, 32'h2, 32'hA5A5_A5A5, 0);
        mem_access("sw400", 1, 2'b00, 32'h400, 32'hCAFE_F00D, 0, 32'hF, 32'hCAFE_F00D, 0);

        // LW with ack three cycles after req
        drive_mem(0, 2'b00, 32'h40, 0);
        for (int i = 0; i < 4; i++) begin
            #1 check("lw_slow_stall", mem_stall, 1);
            if (i > 0) begin
                check("lw_slow_req", dmem_req, 1);
                check("lw_slow_addr", dmem_addr, 32'h40);
                check("lw_slow_be", dmem_be, 0);
                check("lw_slow_wb_hold", wb_alu, 0);
            end
            tick();
        end
        ack = 1; rdata = 32'hDEAD_BEEF;
        #1 check("lw_slow_stall_ack", mem_stall, 0);
        tick();
        check("lw_slow_dato", wb_dato, 32'hDEAD_BEEF);
        check("lw_slow_alu", wb_alu, 32'h40);
        check("lw_slow_rw", wb_rw, 1);
        idle_in();

        misalign("lw6", 0, 2'b00, 32'h6);
        misalign("lh101", 0, 2'b10, 32'h101);
        misalign("s_ill", 1, 2'b11, 32'h0);

        // stray ack while idle
        ack = 1; rdata = 32'hFFFF_FFFF;
        #1 check("stray_ack_stall", mem_stall, 0);
        tick();
        check("stray_ack_req", dmem_req, 0);
        check("stray_ack_dato", wb_dato, 0);
        ack = 0;

        // reset while waiting
        mem_access("lw_pre", 0, 2'b00, 32'h80, 0, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D);
        drive_mem(1, 2'b00, 32'h88, 32'h7777_7777);
        tick();
        check("rstw_req_before", dmem_req, 1);
        i_reset = 1;
        #1 check("rstw_req", dmem_req, 0);
        check("rstw_we", dmem_we, 0);
        check("rstw_addr", dmem_addr, 0);
        check("rstw_wdata", dmem_wdata, 0);
        check("rstw_wb_alu", wb_alu, 0);
        check("rstw_wb_dato", wb_dato, 0);
        idle_in();
        tick();
        i_reset = 0;
        #1 check("rstw_stall", mem_stall, 0);

`ifdef DMEM_TIMEOUT_EN
        drive_mem(0, 2'b00, 32'h500, 0);
        tick();
        for (int i = 1; i < 16; i++) begin
            #1 check("tmo_stall", mem_stall, 1);
            tick();
        end
        #1 check("tmo_release", mem_stall, 0);
        check("tmo_err_pre", dmem_error, 0);
        tick();
        check("tmo_err", dmem_error, 1);
        check("tmo_req", dmem_req, 0);
        check("tmo_wb_rw", wb_rw, 0);
        idle_in();
        tick();
        check("tmo_sticky", dmem_error, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stage_mem_access.md
Name: stage_mem_access

Overview:
- MEM pipeline stage plus MEM/WB latch for the MIPS core.
- Consumes EX/MEM control and data, performs data-memory loads and stores over a req/ack handshake, and stalls the pipeline while an access is outstanding.
- Registers all results into the MEM/WB outputs that feed the write-back mux/load filter.
- Load data leaves this block right-justified (byte/halfword in the low bits); sign/zero extension is done downstream.

Parameters:
BITS_SIZE, 32, datapath/address width
BITS_REGS, 5, register index width
TIMEOUT_CYCLES, 16, ack wait limit (used only with DMEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous active-high reset
i_exmem_valid  in  1  instruction present in EX/MEM
i_exmem_alu  in  BITS_SIZE  ALU result / effective address
i_exmem_data_store  in  BITS_SIZE  store data (rt)
i_exmem_mem_read  in  1  load
i_exmem_mem_write  in  1  store
i_exmem_size_filterL  in  2  load size: 00 word, 01 byte, 10 half, 11 illegal
i_exmem_size_filterS  in  2  store size, same encoding
i_exmem_zero_extend  in  1  unsigned load
i_exmem_lui  in  1  LUI
i_exmem_extension  in  BITS_SIZE  LUI value
i_exmem_mem_to_reg  in  1  write-back source select
i_exmem_reg_write  in  1  register write enable
i_exmem_rd  in  BITS_REGS  destination register
o_dmem_req  out  1  access request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  BITS_SIZE  word-aligned address (low 2 bits zero)
o_dmem_wdata  out  BITS_SIZE  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  access complete; i_dmem_rdata valid this cycle
i_dmem_rdata  in  BITS_SIZE  read word
o_mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM
o_misaligned  out  1  one-cycle pulse: misaligned or illegal access dropped
o_memwb_alu, o_memwb_extension, o_memwb_dato_mem  out  BITS_SIZE each  MEM/WB data
o_memwb_size_filterL  out  2  MEM/WB load size
o_memwb_zero_extend, o_memwb_lui, o_memwb_mem_to_reg, o_memwb_reg_write  out  1 each  MEM/WB control
o_memwb_rd  out  BITS_REGS  MEM/WB destination

Behaviour:
- Reset: async; state IDLE. All o_memwb_*, o_dmem_*, and o_misaligned go to 0 immediately.
- Memory op: mem_op = i_exmem_valid & (mem_read | mem_write).
- Misaligned when:
  - size 10 with addr[0]=1;
  - size 00 with addr[1:0]≠0;
  - size 11 (illegal).
- Misaligned or illegal mem_op: no request is issued. Next edge latches a bubble (reg_write=0) and o_misaligned=1 for one cycle. No stall.
- Non-memory instruction: MEM/WB updated on the next edge (1-cycle latency). reg_write = i_exmem_reg_write & i_exmem_valid.
- FSM IDLE: on an aligned mem_op, o_mem_stall=1 (combinational). Next edge goes to WAIT with registered o_dmem_req=1 and addr/we/wdata/be. MEM/WB latches a bubble.
- FSM WAIT:
  - req and all dmem outputs are held stable until ack.
  - o_mem_stall = !i_dmem_ack.
  - On the ack edge: MEM/WB latches the instruction, req drops, state returns to IDLE.
  - Minimum memory-op latency: 2 cycles.
- Store lanes:
  - byte: be = 1<<addr[1:0]; wdata = byte×4.
  - half: be = addr[1] ? 1100 : 0011; wdata = half×2.
  - word: be = 1111.
- Load alignment:
  - byte: dato_mem = rdata >> 8·addr[1:0].
  - half: dato_mem = rdata >> 16·addr[1].
  - word: dato_mem = rdata unchanged.
  - Upper bits of dato_mem are zero.
- Stores latch reg_write=0 in MEM/WB and dato_mem=0.
- i_dmem_ack seen in IDLE is ignored.
- Reset during WAIT: request abandons immediately; no MEM/WB update.

Optional Feature:
DMEM_TIMEOUT_EN:
- When defined, a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without ack:
  - the access is aborted;
  - a bubble is latched into MEM/WB;
  - the sticky output o_dmem_error (1 bit) is set and cleared only by reset.
- When undefined, WAIT lasts indefinitely and the o_dmem_error port is absent.

Test Plan:
- ADD, alu=0x0000002A, rd=3 -> next edge o_memwb_alu=0x2A, rd=3, reg_write=1; o_mem_stall never asserted.
- LB addr=0x103, rdata=0x80000000, ack on first WAIT cycle -> o_dmem_addr=0x100, be=0; o_memwb_dato_mem=0x00000080, size_filterL=01; stall high exactly 1 cycle.
- SH addr=0x202, data=0x00001234 -> o_dmem_we=1, be=1100, wdata=0x12341234; o_memwb_reg_write=0.
- LW with ack delayed 3 cycles after req -> o_mem_stall high 4 consecutive cycles; dmem outputs constant throughout; MEM/WB updated only on the ack edge.
- LW addr=0x6 -> no o_dmem_req; o_misaligned pulses 1 cycle; o_memwb_reg_write=0.
- Reset asserted mid-WAIT -> o_dmem_req=0 immediately and all outputs 0. With DMEM_TIMEOUT_EN and no ack: after 16 WAIT cycles o_dmem_error=1 and stall releases.
